// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_disp_pkg
// Purpose  : Shared types and constants for the hex display arbiter:
//            arbiter state encoding, owner codes, the blank segment pattern
//            and the 0-F seven-segment lookup table (active-low {g..a}).
// Ports    : n/a (package)
// Revision : 1.0  initial release
// ============================================================================
package hex_disp_pkg;

    // Owner codes double as the state encoding, so the owner output is the
    // state register itself.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_0    = 2'b01;
    localparam logic [1:0] OWNER_1    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    // All segments off (active low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment patterns for nibble values 0..F, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage : hex_disp_pkg
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decode
// Purpose  : One hex digit: 4-bit nibble to active-low seven-segment pattern,
//            with a blank override that turns every segment off.
// Ports    : nibble [3:0] in  - hex value to show
//            blank        in  - 1 forces all segments off
//            seg    [6:0] out - segments {g,f,e,d,c,b,a}, active low
// Revision : 1.0  initial release
// ============================================================================
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_lookup(nibble);
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule : hex_seg_decode
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Purpose  : Shares a four-digit hex display between requester 0 (CPU PIO,
//            high priority) and requester 1 (game logic). Each accepted value
//            owns the display for HOLD_CYCLES clocks before the other side
//            may take over; the owner may refresh its value at any time,
//            which restarts the window.
// Ports    : clk, reset (async, active high)
//            valid0/data0[15:0]/ready0 - requester 0 handshake
//            valid1/data1[15:0]/ready1 - requester 1 handshake
//            blank_lz                  - blank leading zero digits 1..3
//            owner[1:0]                - 00 none, 01 port 0, 10 port 1
//            disp_value[15:0]          - value currently displayed
//            hex0..hex3[6:0]           - active-low segments, hex0 = LS nibble
// Revision : 1.0  initial release
// ============================================================================
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid0,
    input  logic [15:0] data0,
    output logic        ready0,
    input  logic        valid1,
    input  logic [15:0] data1,
    output logic        ready1,
    input  logic        blank_lz,
    output logic [1:0]  owner,
    output logic [15:0] disp_value,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    localparam logic [CNT_W-1:0] c_hold_reload = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [15:0]      r_disp;
    logic [15:0]      w_disp_nxt;

    logic             w_open;      // no live window: either side may win
    logic             w_accept0;
    logic             w_accept1;
    logic [3:0]       w_blank;

    // ------------------------------------------------------------------
    // Ready generation. When the window is open port 0 always has priority,
    // so port 1 is only offered the display while port 0 is not asking.
    // Both readies are held low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_open = (r_state == ST_IDLE) || (r_cnt == '0);
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!reset) begin
            if (w_open) begin
                ready0 = 1'b1;
                ready1 = !valid0;
            end else begin
                ready0 = (r_state == ST_OWN0);
                ready1 = (r_state == ST_OWN1);
            end
        end
    end

    assign w_accept0 = valid0 && ready0;
    assign w_accept1 = valid1 && ready1;

    // ------------------------------------------------------------------
    // Next-state / counter / display logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_disp_nxt  = r_disp;

        if (w_accept0) begin
            w_state_nxt = ST_OWN0;
            w_cnt_nxt   = c_hold_reload;
            w_disp_nxt  = data0;
        end else if (w_accept1) begin
            w_state_nxt = ST_OWN1;
            w_cnt_nxt   = c_hold_reload;
            w_disp_nxt  = data1;
        end else if (r_state != ST_IDLE) begin
            if (r_cnt == '0) begin
                // Expired with nobody asking: release ownership, keep the
                // last value on the display.
                w_state_nxt = ST_IDLE;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_disp  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    assign owner      = r_state;
    assign disp_value = r_disp;

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit k goes dark only when it and every
    // more-significant nibble are zero. Digit 0 always shows.
    // ------------------------------------------------------------------
    always_comb begin
        w_blank[0] = 1'b0;
        w_blank[3] = blank_lz && (r_disp[15:12] == 4'h0);
        w_blank[2] = w_blank[3] && (r_disp[11:8] == 4'h0);
        w_blank[1] = w_blank[2] && (r_disp[7:4] == 4'h0);
    end

    hex_seg_decode u_dec0 (
        .nibble (r_disp[3:0]),
        .blank  (w_blank[0]),
        .seg    (hex0)
    );

    hex_seg_decode u_dec1 (
        .nibble (r_disp[7:4]),
        .blank  (w_blank[1]),
        .seg    (hex1)
    );

    hex_seg_decode u_dec2 (
        .nibble (r_disp[11:8]),
        .blank  (w_blank[2]),
        .seg    (hex2)
    );

    hex_seg_decode u_dec3 (
        .nibble (r_disp[15:12]),
        .blank  (w_blank[3]),
        .seg    (hex3)
    );

endmodule : hex_display_arbiter
`default_nettype wire

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
Shares the four-digit hex display between two requesters: port 0 (CPU hex-digit PIO value, high priority) and port 1 (hardware game logic, e.g. score). Each accepted 16-bit value is held on the display for a minimum ownership window before the other requester may take over. Drives four active-low seven-segment digits, with optional leading-zero blanking. Sits between the SoC PIO / game datapath and the HEX pins.

Parameters:
HOLD_CYCLES, 50_000_000, ownership window in clk cycles after each accept (1 s at 50 MHz); legal range ≥1.
CNT_W, 26, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES-1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
valid0  in  1  requester 0 presents data0
data0  in  16  requester 0 value (4 hex nibbles)
ready0  out  1  requester 0 accepted this cycle when valid0&ready0
valid1  in  1  requester 1 presents data1
data1  in  16  requester 1 value
ready1  out  1  requester 1 accepted this cycle when valid1&ready1
blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked)
owner  out  2  00 none, 01 requester 0, 10 requester 1
disp_value  out  16  value currently displayed
hex0..hex3  out  7 each  segments {g,f,e,d,c,b,a}, active low; hex0 = data[3:0]

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset: state IDLE, hold counter 0, disp_value 16'h0000, owner 00, ready0=ready1=0 while reset asserted; hex0 shows 0 (7'h40), hex1..3 per blank_lz (7'h7F if blank_lz=1, else 7'h40).
- States: IDLE, OWN0, OWN1. owner output = state encoding.
- IDLE: ready0=1; ready1=!valid0. Accept port 0 if valid0 (priority), else port 1 if valid1.
- OWNx, cnt>0: owner's ready=1, other's ready=0. Owner accept reloads window.
- OWNx, cnt==0 (expired): ready0=1; ready1=!valid0. Same priority as IDLE. No valid -> IDLE next cycle; display retained.
- Accept on edge T: disp_value<=data, state<=OWN of accepted port, cnt<=HOLD_CYCLES-1. Visible on disp_value/hex outputs after edge T (1-cycle latency).
- Otherwise in OWNx: cnt decrements by 1 when cnt>0; never wraps below 0.
- HOLD_CYCLES=1: cnt loads 0, so window expires on the next cycle.
- Ready is combinational from state, cnt, valid0; data/valid are never sampled without the matching ready.
- Decode: combinational from disp_value and blank_lz. Table 0-F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Digit k (k=1..3) blanked (7'h7F) iff blank_lz=1 and nibbles k..3 are all zero.
- Reset asserted mid-window: immediate return to reset values; no pending accept survives.

Decomposition:
- Package hex_disp_pkg: state enum (IDLE/OWN0/OWN1), owner codes, SEG_BLANK=7'h7F, 16-entry segment constant table.
- Sub-module hex_seg_decode: 4-bit nibble + blank -> 7-bit segments. Instantiate 4 times.
- Arbiter FSM and counter in the top module.

Test Plan:
- Reset with blank_lz=1 -> disp_value=0000, owner=00, hex0=40, hex1..3=7F; ready0=ready1=0 during reset, both 1 after reset with no valid.
- HOLD_CYCLES=4: valid1 with 16'h00A5 in IDLE -> accepted, next cycle owner=10, hex0=12, hex1=08, hex2/3=7F.
- Same window, valid0 with 16'h1234 held high -> ready0=0 for 3 cycles, accepted on 4th, then owner=01, disp_value=1234.
- Both valid in IDLE (0xBEEF / 0x0001) -> port 0 wins, ready1=0, disp_value=BEEF; port 1 accepted only after window expires and valid0 drops.
- Owner refresh: port 1 re-sends 0x0002 at cnt==1 -> cnt reloads 3, valid0 stays stalled 4 more cycles.
- Expiry with no valid -> owner=00 one cycle after cnt==0, disp_value unchanged. Assert reset mid-window -> immediate reset values.
